// File: rtl/bf16_pkg.sv
// bf16_pkg: shared definitions for the BF16 arithmetic blocks.
//   - format widths and exponent bias
//   - canonical NaN / infinity encodings
//   - packed sign/exponent/mantissa view and operand class decode
package bf16_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 7;
   localparam int BIAS  = 127;

   localparam logic [15:0] QNAN = 16'h7FC0;
   localparam logic [15:0] PINF = 16'h7F80;
   localparam logic [15:0] NINF = 16'hFF80;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } bf16_t;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } bf16_class_t;

   // Subnormals decode as zero: the datapath flushes denormal inputs.
   function automatic bf16_class_t bf16_classify(input logic [EXP_W-1:0] exp,
                                                 input logic [MAN_W-1:0] man);
      bf16_class_t cls;
      if (exp == '0)
         cls = CLS_ZERO;
      else if (exp != '1)
         cls = CLS_NORM;
      else if (man == '0)
         cls = CLS_INF;
      else if (man[MAN_W-1])
         cls = CLS_QNAN;
      else
         cls = CLS_SNAN;
      return cls;
   endfunction

endpackage

// File: rtl/bf16_lzc.sv
// bf16_lzc: leading-zero count over the 11-bit normalise field
// (hidden bit, 7 mantissa bits, guard, round, sticky).
//   val   : field to examine
//   count : number of zeros above the most significant one (11 when val==0)
module bf16_lzc (
   input  logic [10:0] val,
   output logic [3:0]  count
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      count = 4'd11;
      for (int i = 0; i < 11; i++) begin
         if (val[i])
            count = 4'(10 - i);
      end
   end

endmodule

// File: rtl/bf16_adder_pipe.sv
// bf16_adder_pipe: bfloat16 adder, combinational add with one output register.
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset, clears result and flags
//   num1, num2   : BF16 operands
//   result       : registered BF16 sum (round to nearest even, DAZ/FTZ)
//   zero         : result is +0 / -0
//   underflow    : nonzero exact sum flushed to zero
//   overflow     : finite operands rounded to infinity
//   qNaN         : quiet NaN input or inf - inf
//   sNaN         : signalling NaN input
//   positive_inf : result is +inf
//   negative_inf : result is -inf
module bf16_adder_pipe
   import bf16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] num1,
   input  logic [15:0] num2,
   output logic [15:0] result,
   output logic        zero,
   output logic        underflow,
   output logic        overflow,
   output logic        qNaN,
   output logic        sNaN,
   output logic        positive_inf,
   output logic        negative_inf
);

   localparam logic signed [9:0] EXP_INF = 10'(2 * BIAS + 1);

   bf16_t       a, b;
   bf16_class_t ca, cb;

   logic              big_sign;
   logic [7:0]        big_exp, small_exp;
   logic [6:0]        big_man, small_man;
   logic [7:0]        d;
   logic [10:0]       ma, mb_full, mb_sh, mb_mask, mb_al;
   logic              eff_sub;
   logic [11:0]       sum;
   logic [3:0]        lz;
   logic [10:0]       norm;
   logic signed [9:0] exp_n, exp_r;
   logic              round_up;
   logic [8:0]        rnd;
   logic [6:0]        man_r;

   logic [15:0] n_result;
   logic        n_zero, n_underflow, n_overflow, n_qnan, n_snan, n_pinf, n_ninf;

   assign a  = num1;
   assign b  = num2;
   assign ca = bf16_classify(a.exp, a.man);
   assign cb = bf16_classify(b.exp, b.man);

   // Order by magnitude, then align the smaller operand with G/R/S bits.
   always_comb begin
      if ({b.exp, b.man} > {a.exp, a.man}) begin
         big_sign  = b.sign;
         big_exp   = b.exp;
         big_man   = b.man;
         small_exp = a.exp;
         small_man = a.man;
      end else begin
         big_sign  = a.sign;
         big_exp   = a.exp;
         big_man   = a.man;
         small_exp = b.exp;
         small_man = b.man;
      end
      d       = big_exp - small_exp;
      ma      = {1'b1, big_man, 3'b000};
      mb_full = {1'b1, small_man, 3'b000};
      mb_sh   = mb_full >> d;
      mb_mask = (11'd1 << d) - 11'd1;
      // Beyond 10 places every bit has left the field; only sticky survives.
      if (d > 8'd10)
         mb_al = 11'd1;
      else
         mb_al = mb_sh | {10'd0, |(mb_full & mb_mask)};
      eff_sub = a.sign ^ b.sign;
      if (eff_sub)
         sum = {1'b0, ma} - {1'b0, mb_al};
      else
         sum = {1'b0, ma} + {1'b0, mb_al};
   end

   bf16_lzc u_lzc (
      .val   (sum[10:0]),
      .count (lz)
   );

   // Normalise, then round to nearest even on the G/R/S tail.
   always_comb begin
      if (!eff_sub && sum[11]) begin
         norm  = {sum[11:2], sum[1] | sum[0]};
         exp_n = $signed({2'b00, big_exp}) + 10'sd1;
      end else begin
         norm  = sum[10:0] << lz;
         exp_n = $signed({2'b00, big_exp}) - $signed({6'd0, lz});
      end
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd      = {1'b0, norm[10:3]} + {8'd0, round_up};
      exp_r    = exp_n + $signed({9'd0, rnd[8]});
      man_r    = rnd[8] ? rnd[7:1] : rnd[6:0];
   end

   always_comb begin
      n_result    = {big_sign, exp_r[7:0], man_r};
      n_zero      = 1'b0;
      n_underflow = 1'b0;
      n_overflow  = 1'b0;
      n_qnan      = 1'b0;
      n_snan      = 1'b0;
      n_pinf      = 1'b0;
      n_ninf      = 1'b0;
      if (ca == CLS_SNAN || cb == CLS_SNAN) begin
         n_result = QNAN;
         n_snan   = 1'b1;
      end else if (ca == CLS_QNAN || cb == CLS_QNAN ||
                   (ca == CLS_INF && cb == CLS_INF && eff_sub)) begin
         n_result = QNAN;
         n_qnan   = 1'b1;
      end else if (ca == CLS_INF) begin
         n_result = a.sign ? NINF : PINF;
         n_pinf   = ~a.sign;
         n_ninf   = a.sign;
      end else if (cb == CLS_INF) begin
         n_result = b.sign ? NINF : PINF;
         n_pinf   = ~b.sign;
         n_ninf   = b.sign;
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
         n_result = {a.sign & b.sign, 15'd0};
         n_zero   = 1'b1;
      end else if (ca == CLS_ZERO) begin
         n_result = num2;
      end else if (cb == CLS_ZERO) begin
         n_result = num1;
      end else if (sum == 12'd0) begin
         n_result = 16'h0000;
         n_zero   = 1'b1;
      end else if (exp_r >= EXP_INF) begin
         n_result   = big_sign ? NINF : PINF;
         n_overflow = 1'b1;
         n_pinf     = ~big_sign;
         n_ninf     = big_sign;
      end else if (exp_r <= 10'sd0) begin
         n_result    = {big_sign, 15'd0};
         n_underflow = 1'b1;
         n_zero      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result       <= 16'h0000;
         zero         <= 1'b0;
         underflow    <= 1'b0;
         overflow     <= 1'b0;
         qNaN         <= 1'b0;
         sNaN         <= 1'b0;
         positive_inf <= 1'b0;
         negative_inf <= 1'b0;
      end else begin
         result       <= n_result;
         zero         <= n_zero;
         underflow    <= n_underflow;
         overflow     <= n_overflow;
         qNaN         <= n_qnan;
         sNaN         <= n_snan;
         positive_inf <= n_pinf;
         negative_inf <= n_ninf;
      end
   end

endmodule

// File: tb/tb_bf16_adder_pipe.sv
// tb_bf16_adder_pipe: directed and randomized checks of bf16_adder_pipe.
// Flags are compared as {zero, underflow, overflow, qNaN, sNaN, +inf, -inf}.
module tb_bf16_adder_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] num1 = 16'h0000;
   logic [15:0] num2 = 16'h0000;
   logic [15:0] result;
   logic        zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf;

   int errors = 0;
   int checks = 0;

   bf16_adder_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .num1         (num1),
      .num2         (num2),
      .result       (result),
      .zero         (zero),
      .underflow    (underflow),
      .overflow     (overflow),
      .qNaN         (qNaN),
      .sNaN         (sNaN),
      .positive_inf (positive_inf),
      .negative_inf (negative_inf)
   );

   always #5 clk = ~clk;

   wire [6:0] flags = {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf};

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: exact value arithmetic in double, then BF16 round-to-nearest-even.
   function automatic void ref_add(input logic [15:0] x, input logic [15:0] y,
                                   output logic [15:0] r, output logic [6:0] f);
      logic xs, ys, x_snan, y_snan, x_qnan, y_qnan, x_inf, y_inf, x_zero, y_zero, sg;
      real  vx, vy, s, mag, frac, rem;
      int   e, fl, be;
      logic [8:0] flv;
      xs = x[15]; ys = y[15];
      x_snan = (x[14:7] == 8'hFF) && (x[6:0] != 0) && !x[6];
      y_snan = (y[14:7] == 8'hFF) && (y[6:0] != 0) && !y[6];
      x_qnan = (x[14:7] == 8'hFF) && x[6];
      y_qnan = (y[14:7] == 8'hFF) && y[6];
      x_inf  = (x[14:7] == 8'hFF) && (x[6:0] == 0);
      y_inf  = (y[14:7] == 8'hFF) && (y[6:0] == 0);
      x_zero = (x[14:7] == 0);
      y_zero = (y[14:7] == 0);
      f = 7'b0;
      r = 16'h0000;
      if (x_snan || y_snan) begin
         r = 16'h7FC0; f[2] = 1'b1;
      end else if (x_qnan || y_qnan || (x_inf && y_inf && xs != ys)) begin
         r = 16'h7FC0; f[3] = 1'b1;
      end else if (x_inf) begin
         r = {xs, 8'hFF, 7'h00}; if (xs) f[0] = 1'b1; else f[1] = 1'b1;
      end else if (y_inf) begin
         r = {ys, 8'hFF, 7'h00}; if (ys) f[0] = 1'b1; else f[1] = 1'b1;
      end else if (x_zero && y_zero) begin
         r = {xs & ys, 15'd0}; f[6] = 1'b1;
      end else if (x_zero) begin
         r = y;
      end else if (y_zero) begin
         r = x;
      end else begin
         vx = real'(128 + int'(x[6:0])) * pow2(int'(x[14:7]) - 134);
         vy = real'(128 + int'(y[6:0])) * pow2(int'(y[14:7]) - 134);
         if (xs) vx = -vx;
         if (ys) vy = -vy;
         s = vx + vy;
         if (s == 0.0) begin
            r = 16'h0000; f[6] = 1'b1;
         end else begin
            sg  = (s < 0.0);
            mag = sg ? -s : s;
            e   = 0;
            while (mag >= 2.0) begin mag = mag / 2.0; e++; end
            while (mag < 1.0)  begin mag = mag * 2.0; e--; end
            frac = mag * 128.0;
            fl   = $rtoi(frac);
            rem  = frac - $itor(fl);
            if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
            if (fl == 256) begin fl = 128; e++; end
            be = e + 127;
            if (be >= 255) begin
               r = sg ? 16'hFF80 : 16'h7F80; f[4] = 1'b1;
               if (sg) f[0] = 1'b1; else f[1] = 1'b1;
            end else if (be <= 0) begin
               r = {sg, 15'd0}; f[6] = 1'b1; f[5] = 1'b1;
            end else begin
               flv = 9'(fl);
               r = {sg, 8'(be), flv[6:0]};
            end
         end
      end
   endfunction

   function automatic logic [15:0] rand_op(input logic [15:0] other, input bit use_other);
      logic [15:0] v;
      int k, e;
      k = int'($urandom_range(0, 99));
      v = 16'($urandom);
      if (k < 4) begin
         v[14:7] = 8'hFF;
         if (k < 2) v[6:0] = 7'h00;
      end else if (k < 8) begin
         v[14:7] = 8'h00;
      end else if (k < 18) begin
         v[14:7] = 8'($urandom_range(1, 12));
      end else if (k < 28) begin
         v[14:7] = 8'($urandom_range(240, 254));
      end else if (use_other && k < 75) begin
         e = int'(other[14:7]) + int'($urandom_range(0, 12)) - 6;
         if (e < 1) e = 1;
         if (e > 254) e = 254;
         v[14:7] = 8'(e);
         if (k < 50) begin
            v[15]   = ~other[15];
            v[6:0]  = other[6:0] ^ 7'($urandom_range(0, 3));
         end
      end
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      num1 = 16'h3F80; num2 = 16'h3F80;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({result, flags} !== 23'd0) begin
         errors++;
         $display("FAIL reset_state: got %h/%b expected 0000/0000000", result, flags);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [6:0]  f;
   } vec_t;

   task automatic test_directed();
      vec_t v[16];
      v[0]  = '{16'hC20F, 16'h41A4, 16'hC174, 7'b0000000};
      v[1]  = '{16'h4380, 16'h3F80, 16'h4380, 7'b0000000};
      v[2]  = '{16'h4380, 16'h3FC0, 16'h4381, 7'b0000000};
      v[3]  = '{16'h3F80, 16'h3F80, 16'h4000, 7'b0000000};
      v[4]  = '{16'h7F7F, 16'h7F7F, 16'h7F80, 7'b0010010};
      v[5]  = '{16'hFF7F, 16'hFF7F, 16'hFF80, 7'b0010001};
      v[6]  = '{16'h7F80, 16'hFF80, 16'h7FC0, 7'b0001000};
      v[7]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 7'b0001000};
      v[8]  = '{16'h7F81, 16'h3F80, 16'h7FC0, 7'b0000100};
      v[9]  = '{16'h3F80, 16'hBF80, 16'h0000, 7'b1000000};
      v[10] = '{16'h0081, 16'h8080, 16'h0000, 7'b1100000};
      v[11] = '{16'h8000, 16'h8000, 16'h8000, 7'b1000000};
      v[12] = '{16'h0000, 16'h8000, 16'h0000, 7'b1000000};
      v[13] = '{16'h0001, 16'hC000, 16'hC000, 7'b0000000};
      v[14] = '{16'h7F80, 16'h3F80, 16'h7F80, 7'b0000010};
      v[15] = '{16'h7FC0, 16'h7F81, 16'h7FC0, 7'b0000100};
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         num1 = v[i].a; num2 = v[i].b;
         @(posedge clk);
         #1;
         checks++;
         if ({result, flags} !== {v[i].r, v[i].f}) begin
            errors++;
            $display("FAIL directed[%0d] %h+%h: got %h/%b expected %h/%b",
                     i, v[i].a, v[i].b, result, flags, v[i].r, v[i].f);
         end
      end
   endtask

   task automatic test_random_back_to_back();
      logic [15:0] a, b, er;
      logic [6:0]  ef;
      logic [15:0] pa, pb, pr;
      logic [6:0]  pf;
      bit          pending = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (pending) begin
            checks++;
            if ({result, flags} !== {pr, pf}) begin
               errors++;
               $display("FAIL random %h+%h: got %h/%b expected %h/%b",
                        pa, pb, result, flags, pr, pf);
            end
         end
         a = rand_op(16'h0000, 1'b0);
         b = rand_op(a, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            num1 = b; num2 = a;
         end else begin
            num1 = a; num2 = b;
         end
         ref_add(num1, num2, er, ef);
         pa = num1; pb = num2; pr = er; pf = ef;
         pending = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({result, flags} !== {pr, pf}) begin
         errors++;
         $display("FAIL random_last %h+%h: got %h/%b expected %h/%b",
                  pa, pb, result, flags, pr, pf);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      num1 = 16'hC20F; num2 = 16'h41A4;
      @(posedge clk);
      #1;
      checks++;
      if (result !== 16'hC174) begin
         errors++;
         $display("FAIL pre_reset_result: got %h expected c174", result);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({result, flags} !== 23'd0) begin
         errors++;
         $display("FAIL async_reset_immediate: got %h/%b expected 0000/0000000", result, flags);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({result, flags} !== 23'd0) begin
         errors++;
         $display("FAIL reset_held: got %h/%b expected 0000/0000000", result, flags);
      end
      @(negedge clk);
      rst = 1'b0;
      num1 = 16'h3F80; num2 = 16'h3F80;
      #1;
      checks++;
      if ({result, flags} !== 23'd0) begin
         errors++;
         $display("FAIL release_before_edge: got %h/%b expected 0000/0000000", result, flags);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({result, flags} !== {16'h4000, 7'b0}) begin
         errors++;
         $display("FAIL first_after_reset: got %h/%b expected 4000/0000000", result, flags);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
